// File: rtl/seq_alu_if.sv
// Instruction/result bus between register-file read, the sequential ALU and write-back.
interface seq_alu_if #(
   parameter int WIDTH    = 32,
   parameter int IV_WIDTH = 16
);
   logic                In_Valid;
   logic                In_Ready;
   logic [WIDTH-1:0]    Reg1;
   logic [WIDTH-1:0]    Reg2;
   logic [IV_WIDTH-1:0] IV;
   logic [3:0]          OpCode;
   logic [3:0]          Cond;
   logic                S;
   logic                Out_Valid;
   logic [WIDTH-1:0]    Result;
   logic                Write_En;
   logic                Illegal;
   logic [3:0]          Flag;

   modport master (
      output In_Valid, Reg1, Reg2, IV, OpCode, Cond, S,
      input  In_Ready, Out_Valid, Result, Write_En, Illegal, Flag
   );

   modport slave (
      input  In_Valid, Reg1, Reg2, IV, OpCode, Cond, S,
      output In_Ready, Out_Valid, Result, Write_En, Illegal, Flag
   );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with NZCV flags, ARM-style conditional execution and an
// iterative shift-add multiplier; one result pulse per accepted instruction.
module seq_alu #(
   parameter int WIDTH    = 32,
   parameter int IV_WIDTH = 16,
   parameter int SHW      = $clog2(WIDTH)
) (
   input  logic       Clk,
   input  logic       Reset_n,
   seq_alu_if.slave   bus
);
   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_OR  = 4'h3,
                          OP_AND = 4'h4, OP_XOR = 4'h5, OP_MVN = 4'h6, OP_MOV = 4'h7,
                          OP_LSR = 4'h8, OP_LSL = 4'h9, OP_ROR = 4'hA, OP_CMP = 4'hB;

   typedef enum logic {IDLE, MUL} state_t;
   state_t state_q, state_d;

   logic             ov_q, we_q, ill_q;
   logic [WIDTH-1:0] res_q;
   logic [3:0]       flag_q;
   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nx;
   logic [SHW-1:0]   cnt_q;
   logic             mul_s_q;

   logic             accept, cond_ok, cnt_last;
   logic             fn, fz, fc, fv;
   logic [WIDTH-1:0] a, b, res, diff;
   logic [WIDTH:0]   add_w;
   logic [SHW-1:0]   amt, amt_m1, neg_amt;
   logic             c_nx, v_nx, legal, wr, upd;

   assign a        = bus.Reg1;
   assign b        = bus.Reg2;
   assign {fn, fz, fc, fv} = flag_q;
   assign accept   = bus.In_Valid && bus.In_Ready;
   assign cnt_last = &cnt_q;
   assign acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;

   assign bus.In_Ready  = (state_q == IDLE) && Reset_n;
   assign bus.Out_Valid = ov_q;
   assign bus.Result    = res_q;
   assign bus.Write_En  = we_q;
   assign bus.Illegal   = ill_q;
   assign bus.Flag      = flag_q;

   always_comb begin
      cond_ok = 1'b0;
      case (bus.Cond)
         4'h0: cond_ok = fz;
         4'h1: cond_ok = !fz;
         4'h2: cond_ok = fc;
         4'h3: cond_ok = !fc;
         4'h4: cond_ok = fn;
         4'h5: cond_ok = !fn;
         4'h6: cond_ok = fv;
         4'h7: cond_ok = !fv;
         4'h8: cond_ok = fc && !fz;
         4'h9: cond_ok = !fc || fz;
         4'hA: cond_ok = fn == fv;
         4'hB: cond_ok = fn != fv;
         4'hC: cond_ok = !fz && (fn == fv);
         4'hD: cond_ok = fz || (fn != fv);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // Single-cycle datapath; MUL result comes from the iterative path instead.
   always_comb begin
      amt     = bus.IV[SHW-1:0];
      amt_m1  = amt - 1'b1;
      neg_amt = ~amt + 1'b1;
      add_w   = {1'b0, a} + {1'b0, b};
      diff    = a - b;
      res     = '0;
      c_nx    = fc;
      v_nx    = fv;
      legal   = 1'b1;
      wr      = 1'b1;
      upd     = bus.S;
      case (bus.OpCode)
         OP_ADD: begin
            res  = add_w[WIDTH-1:0];
            c_nx = add_w[WIDTH];
            v_nx = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res  = diff;
            c_nx = a >= b;
            v_nx = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            if (bus.OpCode == OP_CMP) begin
               wr  = 1'b0;
               upd = 1'b1;
            end
         end
         OP_MUL: res = '0;
         OP_OR:  res = a | b;
         OP_AND: res = a & b;
         OP_XOR: res = a ^ b;
         OP_MVN: res[IV_WIDTH-1:0] = bus.IV;
         OP_MOV: res = b;
         OP_LSR: begin
            res = b >> amt;
            if (amt != '0) c_nx = b[amt_m1];
         end
         OP_LSL: begin
            res = b << amt;
            if (amt != '0) c_nx = b[neg_amt];
         end
         OP_ROR: begin
            // neg_amt is 0 when amt is 0, so the OR degenerates to b.
            res = (b >> amt) | (b << neg_amt);
            if (amt != '0) c_nx = b[amt_m1];
         end
         default: begin
            legal = 1'b0;
            wr    = 1'b0;
            upd   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && cond_ok && bus.OpCode == OP_MUL) state_d = MUL;
         MUL:     if (cnt_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ov_q     <= 1'b0;
         we_q     <= 1'b0;
         ill_q    <= 1'b0;
         res_q    <= '0;
         flag_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mul_s_q  <= 1'b0;
      end else begin
         ov_q  <= 1'b0;
         we_q  <= 1'b0;
         ill_q <= 1'b0;
         if (state_q == IDLE) begin
            if (accept) begin
               if (!cond_ok) begin
                  ov_q  <= 1'b1;
                  res_q <= '0;
               end else if (bus.OpCode == OP_MUL) begin
                  mcand_q  <= a;
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  mul_s_q  <= bus.S;
               end else begin
                  ov_q  <= 1'b1;
                  res_q <= legal ? res : '0;
                  we_q  <= wr;
                  ill_q <= !legal;
                  if (upd) flag_q <= {res[WIDTH-1], res == '0, c_nx, v_nx};
               end
            end
         end else begin
            acc_q    <= acc_nx;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_last) begin
               ov_q  <= 1'b1;
               res_q <= acc_nx;
               we_q  <= 1'b1;
               if (mul_s_q) flag_q[3:2] <= {acc_nx[WIDTH-1], acc_nx == '0};
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random checks of seq_alu against a plain-arithmetic reference model.
module tb_seq_alu;
   localparam int W   = 32;
   localparam int IVW = 16;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] mflag = 4'b0000;

   seq_alu_if #(.WIDTH(W), .IV_WIDTH(IVW)) bus();
   seq_alu #(.WIDTH(W), .IV_WIDTH(IVW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: condition table, then results from wide integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [3:0] cond,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [15:0] iv, input logic s,
                                 inout logic [3:0] fl, output logic [31:0] r,
                                 output logic we, output logic ill, output int lat,
                                 output logic chk_res);
      logic n, z, c, v, pass, upd;
      logic [32:0] w33;
      logic [63:0] w64;
      longint sx;
      int amt;
      n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
      case (cond)
         0: pass = z;         1: pass = !z;
         2: pass = c;         3: pass = !c;
         4: pass = n;         5: pass = !n;
         6: pass = v;         7: pass = !v;
         8: pass = c && !z;   9: pass = !c || z;
         10: pass = n == v;   11: pass = n != v;
         12: pass = !z && n == v;
         13: pass = z || n != v;
         14: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      r = 0; we = 0; ill = 0; lat = 1; chk_res = 1;
      if (!pass) return;
      we = 1; upd = s; amt = int'(iv[4:0]);
      case (op)
         0: begin
            w33 = {1'b0, a} + {1'b0, b}; r = w33[31:0]; c = w33[32];
            sx = longint'($signed(a)) + longint'($signed(b));
            v = sx != longint'($signed(r));
         end
         1, 11: begin
            r = a - b; c = a >= b;
            sx = longint'($signed(a)) - longint'($signed(b));
            v = sx != longint'($signed(r));
            if (op == 11) begin we = 0; upd = 1; chk_res = 0; end
         end
         2: begin w64 = {32'b0, a} * {32'b0, b}; r = w64[31:0]; lat = W + 1; end
         3: r = a | b;
         4: r = a & b;
         5: r = a ^ b;
         6: r = {16'b0, iv};
         7: r = b;
         8: begin r = b >> amt; if (amt != 0) begin w64 = {32'b0, b} >> (amt - 1); c = w64[0]; end end
         9: begin r = b << amt; w64 = {32'b0, b} << amt; if (amt != 0) c = w64[32]; end
         10: begin w64 = {b, b} >> amt; r = w64[31:0]; if (amt != 0) c = r[31]; end
         default: begin we = 0; ill = 1; upd = 0; r = 0; end
      endcase
      if (upd) fl = {r[31], r == 0, c, v};
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [3:0] cond, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] iv, input logic s,
                         input string tag);
      logic [31:0] er;
      logic ewe, eill, chkr;
      int elat, lat, busy, guard;
      model(op, cond, a, b, iv, s, mflag, er, ewe, eill, elat, chkr);
      guard = 0;
      while (!bus.In_Ready && guard < 100) begin @(posedge Clk); #1; guard++; end
      chk({tag, ".ready"}, 64'(bus.In_Ready), 64'(1));
      bus.In_Valid = 1'b1; bus.OpCode = op; bus.Cond = cond;
      bus.Reg1 = a; bus.Reg2 = b; bus.IV = iv; bus.S = s;
      @(posedge Clk); #1;
      bus.In_Valid = 1'b0;
      lat = 1; busy = 0;
      while (!bus.Out_Valid && lat < 100) begin
         if (!bus.In_Ready) busy++;
         @(posedge Clk); #1; lat++;
      end
      chk({tag, ".lat"},  64'(lat),  64'(elat));
      chk({tag, ".busy"}, 64'(busy), 64'(elat - 1));
      chk({tag, ".we"},   64'(bus.Write_En), 64'(ewe));
      chk({tag, ".ill"},  64'(bus.Illegal),  64'(eill));
      chk({tag, ".flag"}, 64'(bus.Flag),     64'(mflag));
      if (chkr) chk({tag, ".res"}, 64'(bus.Result), 64'(er));
   endtask

   initial begin
      int ovs;
      logic [3:0] op, cond;
      logic [31:0] a, b;
      bus.In_Valid = 0; bus.Reg1 = 0; bus.Reg2 = 0; bus.IV = 0;
      bus.OpCode = 0; bus.Cond = 0; bus.S = 0;
      #12;
      chk("rst.ov",   64'(bus.Out_Valid), 64'(0));
      chk("rst.res",  64'(bus.Result),    64'(0));
      chk("rst.flag", 64'(bus.Flag),      64'(0));
      chk("rst.rdy",  64'(bus.In_Ready),  64'(0));
      @(negedge Clk); Reset_n = 1'b1;
      @(posedge Clk); #1;

      run_op(4'h0, 4'hE, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b1, "add_wrap");
      chk("add_wrap.flag0110", 64'(bus.Flag), 64'(4'b0110));
      run_op(4'hB, 4'hE, 32'd5, 32'd7, 16'h0, 1'b0, "cmp");
      chk("cmp.flag1000", 64'(bus.Flag), 64'(4'b1000));
      run_op(4'h7, 4'hB, 32'h0, 32'hABCD, 16'h0, 1'b0, "mov_lt");
      run_op(4'h2, 4'hE, 32'h0001_0003, 32'h0002_0005, 16'h0, 1'b1, "mul");
      chk("mul.res_const", 64'(bus.Result), 64'(32'h000B_000F));
      run_op(4'h2, 4'h0, 32'h7, 32'h9, 16'h0, 1'b1, "mul_eq_fail");
      run_op(4'hA, 4'hE, 32'h1, 32'h1, 16'h1, 1'b1, "ror1");
      run_op(4'h9, 4'hE, 32'h0, 32'h1234, 16'h0, 1'b1, "lsl0");
      run_op(4'hC, 4'hE, 32'h3, 32'h4, 16'h0, 1'b1, "illegal");
      run_op(4'h6, 4'hE, 32'h0, 32'h0, 16'hBEEF, 1'b1, "movn");
      run_op(4'h8, 4'hE, 32'h0, 32'h8000_0001, 16'h1F, 1'b1, "lsr31");

      for (int i = 0; i < 80; i++) begin
         op   = 4'($urandom_range(0, 15));
         cond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run_op(op, cond, a, b, 16'($urandom), 1'($urandom_range(0, 1)), "rand");
      end

      // Abort a multiply with reset.
      run_op(4'h1, 4'hE, 32'h1, 32'h2, 16'h0, 1'b1, "pre_rst");
      bus.In_Valid = 1'b1; bus.OpCode = 4'h2; bus.Cond = 4'hE;
      bus.Reg1 = 32'h55; bus.Reg2 = 32'h77; bus.S = 1'b1;
      @(posedge Clk); #1; bus.In_Valid = 1'b0;
      repeat (10) @(posedge Clk);
      #2; Reset_n = 1'b0; #1;
      mflag = 4'b0000;
      chk("arst.ov",   64'(bus.Out_Valid), 64'(0));
      chk("arst.res",  64'(bus.Result),    64'(0));
      chk("arst.we",   64'(bus.Write_En),  64'(0));
      chk("arst.ill",  64'(bus.Illegal),   64'(0));
      chk("arst.flag", 64'(bus.Flag),      64'(0));
      chk("arst.rdy",  64'(bus.In_Ready),  64'(0));
      repeat (3) @(posedge Clk);
      @(negedge Clk); Reset_n = 1'b1; #1;
      chk("arst.rdy_after", 64'(bus.In_Ready), 64'(1));
      ovs = 0;
      repeat (40) begin @(posedge Clk); #1; if (bus.Out_Valid) ovs++; end
      chk("arst.no_ov", 64'(ovs), 64'(0));
      run_op(4'h0, 4'hE, 32'h10, 32'h20, 16'h0, 1'b1, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU: same opcode map, plus an internal NZCV flag register, ARM-style condition evaluation, an iterative shift-add multiplier, and a valid/ready input handshake.
- Sits between register-file read and write-back.
- Issues one result per accepted instruction, with a write-enable telling write-back whether to commit.

Parameters:
- WIDTH, 32, datapath width of Reg1/Reg2/Result; must be a power of two, minimum 8.
- IV_WIDTH, 16, immediate width; must be ≤ WIDTH.
- SHW, $clog2(WIDTH), number of IV low bits used as shift/rotate amount.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- In_Valid  in  1  instruction present.
- In_Ready  out  1  block can accept an instruction this cycle.
- Reg1  in  WIDTH  operand A.
- Reg2  in  WIDTH  operand B.
- IV  in  IV_WIDTH  immediate value.
- OpCode  in  4  operation select.
- Cond  in  4  execution condition.
- S  in  1  set-flags request.
- Out_Valid  out  1  one-cycle pulse: Result/Write_En/Illegal are valid.
- Result  out  WIDTH  operation result.
- Write_En  out  1  write-back should commit Result.
- Illegal  out  1  OpCode was not recognised.
- Flag  out  4  current flag register, bit order {N,Z,C,V}.

Behaviour:
- Reset: clocking is synchronous; reset assertion is asynchronous and active-low.
  - While Reset_n=0: Out_Valid=0, Result=0, Write_En=0, Illegal=0, Flag=4'b0000, FSM=IDLE, In_Ready=0.
  - Reset mid-multiply aborts the operation with no output.
- Handshake:
  - In_Ready = (state==IDLE) && Reset_n.
  - An instruction is accepted on a rising edge with In_Valid && In_Ready; inputs are captured at that edge.
  - Out_Valid is a single-cycle pulse with no backpressure.
- FSM states: IDLE, MUL.
  - IDLE + accept of MUL (0010) with condition pass: go to MUL; iteration counter = 0; accumulator = 0.
  - MUL: one shift-add step per cycle. After WIDTH steps, return to IDLE and pulse Out_Valid at the same edge.
  - Total MUL latency: WIDTH+1 edges from accept to Out_Valid.
  - All other accepts stay in IDLE; outputs are registered at the next edge (latency 1). Back-to-back accepts are allowed every cycle.
- Condition, evaluated on Flag at the accept edge; the flag update from the previous instruction is already visible:
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL always
  - 1111 never
- Condition fail (any opcode, MUL included):
  - 1-cycle completion: Out_Valid=1, Write_En=0, Result=0, Illegal=0.
  - Flags unchanged.
- OpCodes; all arithmetic is modulo 2^WIDTH:
  - 0000 ADD: A+B.
  - 0001 SUB: A−B.
  - 0010 MUL: low WIDTH bits of A*B.
  - 0011 OR.
  - 0100 AND.
  - 0101 XOR.
  - 0110 MOVn: zero-extended IV.
  - 0111 MOV: B.
  - 1000 LSR: B >> IV[SHW-1:0].
  - 1001 LSL: B << IV[SHW-1:0].
  - 1010 ROR: B rotated right by IV[SHW-1:0].
  - 1011 CMP: computes A−B; Write_En=0; flags always updated regardless of S.
  - 1100–1111 illegal: Out_Valid=1, Illegal=1, Write_En=0, Result=0, flags unchanged.
- Write_En=1 for every legal, condition-passing opcode except CMP.
- Flags update only when (S=1 or CMP) and the condition passes; the update is written at the Out_Valid edge.
  - N = Result[WIDTH-1]; Z = (Result==0). For CMP these use the internal difference.
  - ADD: C = carry-out; V = signed overflow.
  - SUB/CMP: C = no-borrow (A ≥ B unsigned); V = signed overflow.
  - LSR/LSL/ROR: C = last bit shifted out; amount 0 leaves C unchanged. V unchanged.
  - MUL/OR/AND/XOR/MOV/MOVn: C and V unchanged.
- In MUL state, In_Valid is ignored (In_Ready=0).

Test Plan:
- ADD, Cond=AL, S=1, Reg1=32'hFFFF_FFFF, Reg2=1 -> one cycle later: Out_Valid=1, Result=0, Write_En=1, Flag=0110 (Z,C).
- CMP Reg1=5, Reg2=7, S=0, then next cycle MOV Cond=LT Reg2=32'hABCD -> CMP: Write_En=0, Flag=1000. MOV: Result=32'hABCD, Write_En=1.
- MUL Reg1=32'h0001_0003, Reg2=32'h0002_0005, S=1 -> In_Ready low for 32 cycles; Out_Valid 33 edges after accept; Result=32'h000B_000F; Flag N=0, Z=0, C/V held.
- MUL with Cond=EQ while Z=0 -> Out_Valid after 1 cycle, Write_En=0, Result=0, no busy period.
- ROR Reg2=32'h0000_0001, IV=1, S=1 -> Result=32'h8000_0000, Flag N=1, C=1. LSL with IV=0 -> Result=Reg2, C unchanged.
- OpCode=1100 -> Illegal=1, Write_En=0. Reset_n low 10 cycles into a MUL -> all outputs 0 immediately, In_Ready=1 after release, no Out_Valid for the aborted MUL.
